// File: rtl/fetch_queue_pkg.sv
// Shared types and defaults for the fetch-to-predecode queue.
package fetch_queue_pkg;

  localparam int unsigned FETCH_QUEUE_DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] insn;
    logic        brPredTaken;
    logic [10:0] brGlobalHistory;
  } FetchQueueEntry;

  typedef logic [$clog2(FETCH_QUEUE_DEPTH)-1:0]   FetchQueueIndexPath;
  typedef logic [$clog2(FETCH_QUEUE_DEPTH+1)-1:0] FetchQueueCountPath;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fetch_queue_compactor.sv
// Packs the valid lanes of a holed fetch group into program order and counts them.
module fetch_queue_compactor #(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned ENTRY_W     = 76
) (
  input  logic [FETCH_WIDTH-1:0]         i_valid,
  input  logic [FETCH_WIDTH*ENTRY_W-1:0] i_entry,
  output logic [FETCH_WIDTH*ENTRY_W-1:0] o_entry,
  output logic [$clog2(FETCH_WIDTH+1)-1:0] o_count
);

  localparam int unsigned CW = $clog2(FETCH_WIDTH + 1);

  logic [CW-1:0] w_pos;

  // w_pos is the running prefix sum: the output slot of the current valid lane.
  always_comb begin
    w_pos   = '0;
    o_entry = '0;
    for (int j = 0; j < FETCH_WIDTH; j++) begin
      if (i_valid[j]) begin
        for (int k = 0; k < FETCH_WIDTH; k++) begin
          if (w_pos == CW'(k)) o_entry[k*ENTRY_W +: ENTRY_W] = i_entry[j*ENTRY_W +: ENTRY_W];
        end
      end
      w_pos = w_pos + CW'(i_valid[j]);
    end
    o_count = w_pos;
  end

endmodule

// File: rtl/fetch_queue.sv
// Fetch queue: compacts fetch groups into a circular buffer, delivers in-order decode lanes.
// Define RSD_FETCH_QUEUE_BYPASS_EN to forward incoming lanes to the outputs when empty.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH  = 2,
  parameter int unsigned DECODE_WIDTH = 2,
  parameter int unsigned DEPTH        = FETCH_QUEUE_DEPTH,
  parameter int unsigned ENTRY_W      = 76
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_flush,
  input  logic [FETCH_WIDTH-1:0]            i_in_valid,
  input  logic [FETCH_WIDTH*ENTRY_W-1:0]    i_in_entry,
  output logic                              o_in_ready,
  output logic [DECODE_WIDTH-1:0]           o_out_valid,
  output logic [DECODE_WIDTH*ENTRY_W-1:0]   o_out_entry,
  input  logic [$clog2(DECODE_WIDTH+1)-1:0] i_out_take,
  output logic [$clog2(DEPTH+1)-1:0]        o_count,
  output logic                              o_empty,
  output logic                              o_full
);

  localparam int unsigned IW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned FCW = $clog2(FETCH_WIDTH + 1);
  localparam int unsigned LW  = max_u(FETCH_WIDTH, DECODE_WIDTH);

  logic [ENTRY_W-1:0] r_mem [DEPTH];
  logic [IW-1:0]      r_head, r_tail;
  logic [CW-1:0]      r_count;

  logic [FETCH_WIDTH*ENTRY_W-1:0] w_cmp_flat;
  logic [FCW-1:0]                 w_cmp_n;
  logic [ENTRY_W-1:0]             w_cmp_lane [LW];
  logic [ENTRY_W-1:0]             w_wr_lane [FETCH_WIDTH];
  logic                           w_enq, w_bypass;
  logic [CW-1:0]                  w_avail, w_take, w_deq_n, w_wr_n, w_skip;

  fetch_queue_compactor #(
    .FETCH_WIDTH (FETCH_WIDTH),
    .ENTRY_W     (ENTRY_W)
  ) u_compactor (
    .i_valid (i_in_valid),
    .i_entry (i_in_entry),
    .o_entry (w_cmp_flat),
    .o_count (w_cmp_n)
  );

  // Ready looks only at the pre-dequeue count so out_take never reaches in_ready.
  assign o_in_ready = !i_rst && ((CW'(DEPTH) - r_count) >= CW'(FETCH_WIDTH));
  assign w_enq      = o_in_ready && (|i_in_valid) && !i_flush;

  always_comb begin
    for (int k = 0; k < LW; k++) w_cmp_lane[k] = '0;
    for (int k = 0; k < FETCH_WIDTH; k++) w_cmp_lane[k] = w_cmp_flat[k*ENTRY_W +: ENTRY_W];

    o_out_valid = '0;
    o_out_entry = '0;
    for (int i = 0; i < DECODE_WIDTH; i++) begin
      o_out_valid[i]                     = r_count > CW'(i);
      o_out_entry[i*ENTRY_W +: ENTRY_W]  = r_mem[r_head + IW'(i)];
    end
    w_avail  = (r_count < CW'(DECODE_WIDTH)) ? r_count : CW'(DECODE_WIDTH);
    w_bypass = 1'b0;
`ifdef RSD_FETCH_QUEUE_BYPASS_EN
    if (r_count == '0 && w_enq) begin
      w_bypass = 1'b1;
      for (int i = 0; i < DECODE_WIDTH; i++) begin
        o_out_valid[i]                    = CW'(w_cmp_n) > CW'(i);
        o_out_entry[i*ENTRY_W +: ENTRY_W] = w_cmp_lane[i];
      end
      w_avail = (CW'(w_cmp_n) < CW'(DECODE_WIDTH)) ? CW'(w_cmp_n) : CW'(DECODE_WIDTH);
    end
`endif
    w_take  = (CW'(i_out_take) > w_avail) ? w_avail : CW'(i_out_take);
    w_deq_n = w_bypass ? '0 : w_take;
    w_skip  = w_bypass ? w_take : '0;
    w_wr_n  = w_enq ? (CW'(w_cmp_n) - w_skip) : '0;

    // Bypassed lanes consumed this cycle are skipped; the rest land at tail.
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      w_wr_lane[k] = '0;
      for (int j = 0; j < FETCH_WIDTH; j++) begin
        if (CW'(j) == CW'(k) + w_skip) w_wr_lane[k] = w_cmp_lane[j];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= r_head + IW'(w_deq_n);
      r_tail  <= r_tail + IW'(w_wr_n);
      r_count <= r_count + w_wr_n - w_deq_n;
    end
  end

  // w_wr_n is already zero under reset or flush.
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < FETCH_WIDTH; k++) begin
      if (CW'(k) < w_wr_n) r_mem[r_tail + IW'(k)] <= w_wr_lane[k];
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      assert (CW'(i_out_take) <= w_avail)
        else $error("fetch_queue: out_take exceeds presented valid lanes");
    end
  end

  assign o_count = r_count;
  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CW'(DEPTH));

endmodule
